// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA drawing blocks: the drawer state
// encoding, default screen geometry and a width helper for counters/addresses.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vga_state_e;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_COLOUR_W = 3;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Raster-order x/y counter with a running linear address and a last-pixel flag.
// The address is incremented alongside x/y, so no multiplier is needed.
module vga_raster_counter
    import vga_pkg::*;
#(
    parameter int  WIDTH  = DEF_SCREEN_W,
    parameter int  HEIGHT = DEF_SCREEN_H,
    localparam int X_W    = clog2_min1(WIDTH),
    localparam int Y_W    = clog2_min1(HEIGHT),
    localparam int ADDR_W = clog2_min1(WIDTH * HEIGHT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              x_end;

    assign x_end  = (x_q == X_W'(WIDTH - 1));
    assign last_o = x_end && (y_q == Y_W'(HEIGHT - 1));

    // Compare against WIDTH-1/HEIGHT-1 so non-power-of-two sizes wrap cleanly.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (advance_i) begin
            if (last_o) begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
            end else if (x_end) begin
                x_d    = '0;
                y_d    = y_q + Y_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                x_d    = x_q + X_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/vga_image_blitter.sv
// Full-frame ROM image drawer: on start, streams every pixel of the selected
// image to the VGA adapter in raster order. Optional macro TRANSPARENT_EN.
module vga_image_blitter
    import vga_pkg::*;
#(
    parameter int  SCREEN_W           = DEF_SCREEN_W,
    parameter int  SCREEN_H           = DEF_SCREEN_H,
    parameter int  COLOUR_W           = DEF_COLOUR_W,
    parameter int  NUM_IMAGES         = 4,
    parameter int  ROM_LATENCY        = 1,
    parameter int  TRANSPARENT_COLOUR = 0,
    localparam int SEL_W              = clog2_min1(NUM_IMAGES),
    localparam int X_W                = clog2_min1(SCREEN_W),
    localparam int Y_W                = clog2_min1(SCREEN_H),
    localparam int ADDR_W             = clog2_min1(SCREEN_W * SCREEN_H)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [SEL_W-1:0]    image_sel,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic [SEL_W-1:0]    rom_sel,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x_counter,
    output logic [Y_W-1:0]      y_counter,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done,
    output vga_state_e          dbg_state
);

`ifdef TRANSPARENT_EN
    localparam bit TRANSP_ON = 1'b1;
`else
    localparam bit TRANSP_ON = 1'b0;
`endif

    // Handshake: start is a one-cycle request accepted only in IDLE or DONE;
    // busy is high from the accepting edge until done rises, and done holds
    // until the next accepted start. image_sel is sampled only on acceptance.

    vga_state_e       state_q;
    logic [SEL_W-1:0] rom_sel_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       drain_cnt_q;

    logic             start_accept;
    logic             fetching;
    logic [X_W-1:0]   cnt_x;
    logic [Y_W-1:0]   cnt_y;
    logic             cnt_last;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign fetching     = (state_q == FETCH);

    vga_raster_counter #(
        .WIDTH  (SCREEN_W),
        .HEIGHT (SCREEN_H)
    ) u_raster (
        .clk_i     (clock),
        .rst_i     (reset),
        .clear_i   (start_accept),
        .advance_i (fetching),
        .x_o       (cnt_x),
        .y_o       (cnt_y),
        .addr_o    (rom_addr),
        .last_o    (cnt_last)
    );

    // DRAIN lasts ROM_LATENCY+1 cycles: the delay line plus the output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rom_sel_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= FETCH;
                        rom_sel_q <= image_sel;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (cnt_last) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 3'(ROM_LATENCY)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [X_W-1:0] pipe_x;
    logic [Y_W-1:0] pipe_y;
    logic           pipe_v;

    if (ROM_LATENCY == 0) begin : g_no_delay
        assign pipe_x = cnt_x;
        assign pipe_y = cnt_y;
        assign pipe_v = fetching;
    end else begin : g_delay
        logic [X_W-1:0] dly_x_q [ROM_LATENCY];
        logic [Y_W-1:0] dly_y_q [ROM_LATENCY];
        logic           dly_v_q [ROM_LATENCY];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < ROM_LATENCY; i++) begin
                    dly_x_q[i] <= '0;
                    dly_y_q[i] <= '0;
                    dly_v_q[i] <= 1'b0;
                end
            end else begin
                dly_x_q[0] <= cnt_x;
                dly_y_q[0] <= cnt_y;
                dly_v_q[0] <= fetching;
                for (int i = 1; i < ROM_LATENCY; i++) begin
                    dly_x_q[i] <= dly_x_q[i-1];
                    dly_y_q[i] <= dly_y_q[i-1];
                    dly_v_q[i] <= dly_v_q[i-1];
                end
            end
        end

        assign pipe_x = dly_x_q[ROM_LATENCY-1];
        assign pipe_y = dly_y_q[ROM_LATENCY-1];
        assign pipe_v = dly_v_q[ROM_LATENCY-1];
    end

    logic                pix_plot;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;

    assign pix_plot = pipe_v &&
                      !(TRANSP_ON && (rom_q == COLOUR_W'(TRANSPARENT_COLOUR)));

    // Coordinates and colour update only on plotted pixels, otherwise they hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= pix_plot;
            if (pix_plot) begin
                x_q      <= pipe_x;
                y_q      <= pipe_y;
                colour_q <= rom_q;
            end
        end
    end

    assign rom_sel   = rom_sel_q;
    assign x_counter = x_q;
    assign y_counter = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_image_blitter.sv
// Bench for vga_image_blitter: four instances (4x3 lat 1, 160x120 lat 1,
// 4x3 lat 0, 4x3 lat 3) driven with directed frames; honours TRANSPARENT_EN.
module tb_vga_image_blitter;
  import vga_pkg::*;

  localparam int NDUT = 4;
  localparam int DW[NDUT] = '{4, 160, 4, 4};
  localparam int DH[NDUT] = '{3, 120, 3, 3};
  localparam int DL[NDUT] = '{1, 1, 0, 3};

  logic clk;
  logic rst;
  int   cyc;

  logic        start_a[NDUT];
  logic [1:0]  sel_a[NDUT];
  logic [14:0] addr_a[NDUT];
  logic [7:0]  x_a[NDUT];
  logic [6:0]  y_a[NDUT];
  logic [2:0]  col_a[NDUT];
  logic [1:0]  rsel_a[NDUT];
  logic        plot_a[NDUT];
  logic        busy_a[NDUT];
  logic        done_a[NDUT];
  vga_state_e  st_a[NDUT];

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and ROM models (rom_q = addr[2:0]) ----------------
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int XW = clog2_min1(DW[g]);
    localparam int YW = clog2_min1(DH[g]);
    localparam int AW = clog2_min1(DW[g] * DH[g]);

    logic [AW-1:0] addr;
    logic [XW-1:0] xc;
    logic [YW-1:0] yc;
    logic [2:0]    col;
    logic [2:0]    q;
    logic [1:0]    rsel;
    logic          pl;
    logic          bz;
    logic          dn;
    vga_state_e    st;

    vga_image_blitter #(
      .SCREEN_W           (DW[g]),
      .SCREEN_H           (DH[g]),
      .COLOUR_W           (3),
      .NUM_IMAGES         (4),
      .ROM_LATENCY        (DL[g]),
      .TRANSPARENT_COLOUR (0)
    ) u_dut (
      .clock     (clk),
      .reset     (rst),
      .start     (start_a[g]),
      .image_sel (sel_a[g]),
      .rom_addr  (addr),
      .rom_sel   (rsel),
      .rom_q     (q),
      .x_counter (xc),
      .y_counter (yc),
      .colour    (col),
      .plot      (pl),
      .busy      (bz),
      .done      (dn),
      .dbg_state (st)
    );

    if (DL[g] == 0) begin : g_rom0
      assign q = addr[2:0];
    end else begin : g_romn
      logic [2:0] sh[DL[g]];
      always @(posedge clk) begin
        sh[0] <= addr[2:0];
        for (int i = 1; i < DL[g]; i++) sh[i] <= sh[i-1];
      end
      assign q = sh[DL[g]-1];
    end

    assign addr_a[g] = 15'(addr);
    assign x_a[g]    = 8'(xc);
    assign y_a[g]    = 7'(yc);
    assign col_a[g]  = col;
    assign rsel_a[g] = rsel;
    assign plot_a[g] = pl;
    assign busy_a[g] = bz;
    assign done_a[g] = dn;
    assign st_a[g]   = st;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit visible(input int p);
`ifdef TRANSPARENT_EN
    return (p % 8) != 0;
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- frame monitor ----------------
  bit         mon_en[NDUT];
  int         t0[NDUT];
  logic [1:0] exp_sel[NDUT];
  int         plot_cnt[NDUT], bad_pix[NDUT], first_c[NDUT], last_c[NDUT];
  int         done_c[NDUT], busy_dn[NDUT], busy1[NDUT], done1[NDUT];
  int         sel_bad[NDUT], pix_idx[NDUT];
  bit         cap_ok[16];
  int         cap_x[16], cap_y[16], cap_c[16];
  int         mon_rel, mon_e;

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (mon_en[d]) begin
        mon_rel = cyc - t0[d];
        if (mon_rel == 1) begin
          busy1[d] = int'(busy_a[d]);
          done1[d] = int'(done_a[d]);
        end
        if (mon_rel >= 1 && rsel_a[d] != exp_sel[d]) sel_bad[d]++;
        if (plot_a[d]) begin
          mon_e = pix_idx[d];
          while (mon_e < DW[d] * DH[d] && !visible(mon_e)) mon_e++;
          if (first_c[d] < 0) first_c[d] = mon_rel;
          last_c[d] = mon_rel;
          plot_cnt[d]++;
          if (mon_e >= DW[d] * DH[d] ||
              int'(x_a[d]) != mon_e % DW[d] ||
              int'(y_a[d]) != mon_e / DW[d] ||
              int'(col_a[d]) != mon_e % 8 ||
              mon_rel != DL[d] + 2 + mon_e)
            bad_pix[d]++;
          if (d == 0 && mon_e < 16) begin
            cap_ok[mon_e] = 1'b1;
            cap_x[mon_e]  = int'(x_a[d]);
            cap_y[mon_e]  = int'(y_a[d]);
            cap_c[mon_e]  = int'(col_a[d]);
          end
          pix_idx[d] = mon_e + 1;
        end
        if (mon_rel >= 1 && done_a[d] && done_c[d] < 0) begin
          done_c[d]  = mon_rel;
          busy_dn[d] = int'(busy_a[d]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input int d, input logic [1:0] sel, input int pulse_rel);
    int npix, exp_cnt, fv, lv, k;
    npix = DW[d] * DH[d];
    exp_cnt = 0;
    fv = -1;
    lv = -1;
    for (int p = 0; p < npix; p++) begin
      if (visible(p)) begin
        exp_cnt++;
        if (fv < 0) fv = p;
        lv = p;
      end
    end
    @(posedge clk); #2;
    t0[d] = cyc;
    exp_sel[d] = sel;
    plot_cnt[d] = 0; bad_pix[d] = 0; first_c[d] = -1; last_c[d] = -1;
    done_c[d] = -1; busy_dn[d] = -1; busy1[d] = -1; done1[d] = -1;
    sel_bad[d] = 0; pix_idx[d] = 0;
    for (int i = 0; i < 16; i++) cap_ok[i] = 1'b0;
    start_a[d] = 1'b1;
    sel_a[d] = sel;
    mon_en[d] = 1'b1;
    k = 0;
    while (done_c[d] < 0 && k < npix + DL[d] + 20) begin
      @(posedge clk); #2;
      k++;
      start_a[d] = (pulse_rel > 0 && (cyc - t0[d]) == pulse_rel);
      sel_a[d] = start_a[d] ? ~sel : sel;
    end
    start_a[d] = 1'b0;
    @(negedge clk);
    mon_en[d] = 1'b0;
    check("done_seen", int'(done_c[d] >= 0), 1);
    check("plot_count", plot_cnt[d], exp_cnt);
    check("bad_pixels", bad_pix[d], 0);
    check("first_plot_cycle", first_c[d], DL[d] + 2 + fv);
    check("last_plot_cycle", last_c[d], DL[d] + 2 + lv);
    check("done_cycle", done_c[d], DL[d] + 2 + npix);
    check("busy_at_done", busy_dn[d], 0);
    check("busy_cycle1", busy1[d], 1);
    check("done_cycle1", done1[d], 0);
    check("rom_sel_stable", sel_bad[d], 0);
    check("rom_sel", int'(rsel_a[d]), int'(sel));
    check("state_done", int'(st_a[d]), int'(DONE));
    if (d == 0) begin
      check("pix0_plotted", int'(cap_ok[0]), int'(visible(0)));
      check("pix4_plotted", int'(cap_ok[4]), 1);
      check("pix4_x", cap_x[4], 0);
      check("pix4_y", cap_y[4], 1);
      check("pix4_colour", cap_c[4], 4);
      check("pix11_x", cap_x[11], 3);
      check("pix11_y", cap_y[11], 2);
      check("pix11_colour", cap_c[11], 3);
    end
  endtask

  task automatic hold_done(input int d, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_a[d] && !busy_a[d] && !plot_a[d]) cnt++;
    end
    check("done_hold", cnt, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      start_a[d] = 1'b0;
      sel_a[d] = 2'd0;
      mon_en[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("rst_addr", int'(addr_a[0]), 0);
    check("rst_x", int'(x_a[0]), 0);
    check("rst_y", int'(y_a[0]), 0);
    check("rst_colour", int'(col_a[0]), 0);
    check("rst_rom_sel", int'(rsel_a[0]), 0);
    check("rst_state", int'(st_a[0]), int'(IDLE));
    for (int d = 0; d < NDUT; d++) begin
      check("rst_plot", int'(plot_a[d]), 0);
      check("rst_busy", int'(busy_a[d]), 0);
      check("rst_done", int'(done_a[d]), 0);
    end
    rst = 1'b0;

    // 4x3, latency 1, image 2
    run_frame(0, 2'd2, -1);
    hold_done(0, 5);

    // restart from DONE; a second start mid-frame must be ignored
    run_frame(0, 2'd3, 7);

    // reset while fetching pixel 5 aborts the frame
    @(posedge clk); #2;
    start_a[0] = 1'b1;
    sel_a[0] = 2'd1;
    @(posedge clk); #2;
    start_a[0] = 1'b0;
    k = 0;
    while (addr_a[0] != 15'd5 && k < 50) begin
      @(posedge clk); #2;
      k++;
    end
    check("mid_reset_reached", int'(addr_a[0]), 5);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("abort_plot", int'(plot_a[0]), 0);
    check("abort_busy", int'(busy_a[0]), 0);
    check("abort_done", int'(done_a[0]), 0);
    check("abort_state", int'(st_a[0]), int'(IDLE));
    check("abort_addr", int'(addr_a[0]), 0);
    run_frame(0, 2'd1, -1);

    // latency sweeps
    run_frame(2, 2'd0, -1);
    run_frame(3, 2'd2, -1);

    // full 160x120 frame, then done must hold
    run_frame(1, 2'd1, -1);
    hold_done(1, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
